// File: rtl/xor_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial XOR controller.
//   state_t : FSM encoding (2'b11 is unreachable and is decoded as IDLE)
//   XOR_W   : default operand/result width
package xor_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int XOR_W = 8;

endpackage

// File: rtl/xor_serial_ctrl_nand.sv
// xor_nand_cell: one-bit XOR built from four NAND gates. Purely combinational.
//   a, b : input bits
//   s    : a XOR b
module xor_nand_cell (
    output logic s,
    input  logic a,
    input  logic b
);

    logic n;
    logic m;
    logic o;

    assign n = ~(a & b);
    assign m = ~(a & n);
    assign o = ~(b & n);
    assign s = ~(m & o);

endmodule

// File: rtl/xor_serial_ctrl.sv
// xor_serial_ctrl: streams two W-bit operands LSB first through a single
// NAND-built XOR cell, one bit per clock, and returns the XOR word and parity.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high clear
//   start  : begin an operation (only honoured in IDLE)
//   a, b   : operands, captured on the accepted start edge
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse while in DONE
//   result : a ^ b, valid from DONE entry, held until the next accepted start
//   parity : XOR-reduction of result, same validity as result
module xor_serial_ctrl
    import xor_serial_ctrl_pkg::*;
#(
    parameter int W = XOR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         parity
);

    localparam int             CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  rsh;
    logic [W-1:0]  rsh_nxt;
    logic [CW-1:0] cnt;
    logic          pacc;
    logic          x;

    // The only source of XOR bits for the result word.
    xor_nand_cell u_cell (
        .s (x),
        .a (sa[0]),
        .b (sb[0])
    );

    // New bits enter at the MSB so bit 0 has reached the LSB after W shifts.
    generate
        if (W == 1) begin : g_rsh_w1
            assign rsh_nxt = x;
        end else begin : g_rsh_wn
            assign rsh_nxt = {x, rsh[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            parity <= 1'b0;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            rsh    <= '0;
            pacc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
                        rsh   <= '0;
                        pacc  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    rsh  <= rsh_nxt;
                    pacc <= pacc ^ x;
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    if (cnt == CNT_LAST) begin
                        // Publish the final shift/accumulate values, including this edge's bit.
                        result <= rsh_nxt;
                        parity <= pacc ^ x;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
